// File: rtl/transport_send_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : transport_send_pkg
//  Description : Definitions shared by the transport-layer send path and its
//                receive-side counterpart: word type codes, header byte
//                construction, default packet size and the send FSM state
//                encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package transport_send_pkg;

    // Default number of 16-bit words carried by one audio packet.
    localparam int c_def_audio_words = 8;

    // Session-layer word type codes.
    localparam logic [1:0] c_type_none  = 2'b00;
    localparam logic [1:0] c_type_ctrl  = 2'b01;
    localparam logic [1:0] c_type_audio = 2'b10;
    localparam logic [1:0] c_type_rsvd  = 2'b11;

    // Send FSM states.
    //   ST_IDLE     : no audio buffered
    //   ST_FILL     : a partial audio packet is buffered
    //   ST_WAIT_NET : a packet is armed, waiting for the network layer
    //   ST_HEADER   : header byte on the bus
    //   ST_PAYLOAD  : payload bytes on the bus
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_WAIT_NET = 3'd2,
        ST_HEADER   = 3'd3,
        ST_PAYLOAD  = 3'd4
    } state_t;

    // Header byte: the two type bits in the top of the byte, rest zero.
    function automatic logic [7:0] hdr_byte(input logic [1:0] pkt_type);
        return {pkt_type, 6'b00_0000};
    endfunction

endpackage : transport_send_pkg
`default_nettype wire

// File: rtl/transport_word_buf.sv
`default_nettype none
// ============================================================================
//  Module      : transport_word_buf
//  Description : Audio word buffer for the transport send path. Holds
//                AUDIO_WORDS x 16-bit words written by word pointer and read
//                back one byte at a time by byte index (word = index >> 1,
//                index[0] = 0 selects the high byte).
//
//  Ports       : clk        system clock
//                reset      asynchronous active-low reset (clears contents)
//                i_wr_en    write strobe
//                i_wr_ptr   word slot to write
//                i_wr_data  word to store
//                i_rd_idx   byte index to read
//                o_rd_byte  selected byte (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module transport_word_buf #(
    parameter  int AUDIO_WORDS = 8,
    localparam int PTR_W       = $clog2(AUDIO_WORDS + 1),
    localparam int CNT_W       = $clog2(2 * AUDIO_WORDS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [PTR_W-1:0] i_wr_ptr,
    input  logic [15:0]      i_wr_data,
    input  logic [CNT_W-1:0] i_rd_idx,
    output logic [7:0]       o_rd_byte
);

    logic [15:0]      r_mem [AUDIO_WORDS];
    logic [CNT_W-2:0] w_word_sel;
    logic [15:0]      w_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < AUDIO_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            for (int i = 0; i < AUDIO_WORDS; i++) begin
                if (i_wr_ptr == PTR_W'(i)) begin
                    r_mem[i] <= i_wr_data;
                end
            end
        end
    end

    assign w_word_sel = i_rd_idx[CNT_W-1:1];

    // The index one past the last byte selects no word and reads as zero;
    // the FSM never puts that value on the bus.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < AUDIO_WORDS; i++) begin
            if (w_word_sel == (CNT_W-1)'(i)) begin
                w_word = r_mem[i];
            end
        end
    end

    assign o_rd_byte = i_rd_idx[0] ? w_word[7:0] : w_word[15:8];

endmodule : transport_word_buf
`default_nettype wire

// File: rtl/transport_send.sv
`default_nettype none
// ============================================================================
//  Module      : transport_send
//  Description : Transmit side of the transport layer. Frames 16-bit session
//                words into byte packets for the network layer. Audio words
//                are collected into AUDIO_WORDS-word packets; a control word
//                is sent at once as a single-word packet, preempting a
//                partially filled audio buffer which is resumed afterwards.
//                Packet = header byte {type, 6'b0} followed by payload bytes,
//                MSB first, one byte per clock while sendSignal is high.
//
//  Ports       : clk            system clock
//                reset          asynchronous active-low reset
//                sessionType    word type (00 none, 01 ctrl, 10 audio, 11 rsvd)
//                sessionData    word from session layer
//                sessionValid   word offered this cycle
//                transportBusy  high while a packet is armed or being sent
//                netBusy        network layer cannot start a packet
//                sendSignal     high for exactly the bytes of one packet
//                packetOut      packet byte, valid while sendSignal is high
//  Revision    : 1.0  initial release
// ============================================================================
module transport_send
    import transport_send_pkg::*;
#(
    parameter int AUDIO_WORDS = c_def_audio_words
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  sessionType,
    input  logic [15:0] sessionData,
    input  logic        sessionValid,
    output logic        transportBusy,
    input  logic        netBusy,
    output logic        sendSignal,
    output logic [7:0]  packetOut
);

    localparam int PTR_W = $clog2(AUDIO_WORDS + 1);
    localparam int CNT_W = $clog2(2 * AUDIO_WORDS + 1);

    // Byte-counter value reached once the final payload byte is on the bus.
    localparam logic [CNT_W-1:0] c_audio_last = CNT_W'(2 * AUDIO_WORDS);
    localparam logic [CNT_W-1:0] c_ctrl_last  = CNT_W'(2);
    localparam logic [PTR_W-1:0] c_last_slot  = PTR_W'(AUDIO_WORDS - 1);

    state_t           r_state;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [15:0]      r_ctrl_reg;
    logic             r_ret_fill;   // control packet returns to FILL, else IDLE
    logic             r_pkt_audio;  // armed / in-flight packet is audio
    logic [CNT_W-1:0] r_byte_cnt;   // payload byte index

    logic             w_accept;
    logic             w_buf_wr;
    logic [7:0]       w_buf_byte;
    logic [7:0]       w_pay_byte;
    logic             w_last_byte;

    // Busy depends on state only, so the session layer never sees a
    // combinational path from its own inputs.
    assign transportBusy = (r_state inside {ST_WAIT_NET, ST_HEADER, ST_PAYLOAD});
    assign w_accept      = sessionValid && !transportBusy;
    assign w_buf_wr      = w_accept && (sessionType == c_type_audio);

    transport_word_buf #(
        .AUDIO_WORDS (AUDIO_WORDS)
    ) u_word_buf (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_buf_wr),
        .i_wr_ptr  (r_wr_ptr),
        .i_wr_data (sessionData),
        .i_rd_idx  (r_byte_cnt),
        .o_rd_byte (w_buf_byte)
    );

    // Next payload byte for the current counter position.
    assign w_pay_byte  = r_pkt_audio ? w_buf_byte
                       : (r_byte_cnt[0] ? r_ctrl_reg[7:0] : r_ctrl_reg[15:8]);
    assign w_last_byte = r_pkt_audio ? (r_byte_cnt == c_audio_last)
                                     : (r_byte_cnt == c_ctrl_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_ctrl_reg  <= '0;
            r_ret_fill  <= 1'b0;
            r_pkt_audio <= 1'b0;
            r_byte_cnt  <= '0;
            sendSignal  <= 1'b0;
            packetOut   <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE, ST_FILL: begin
                    if (w_accept) begin
                        case (sessionType)
                            c_type_audio: begin
                                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                                if (r_wr_ptr == c_last_slot) begin
                                    r_pkt_audio <= 1'b1;
                                    r_byte_cnt  <= '0;
                                    r_state     <= ST_WAIT_NET;
                                end else begin
                                    r_state <= ST_FILL;
                                end
                            end
                            c_type_ctrl: begin
                                // Buffered audio and wrPtr stay as they are;
                                // only the state to come back to is recorded.
                                r_ctrl_reg  <= sessionData;
                                r_ret_fill  <= (r_state == ST_FILL);
                                r_pkt_audio <= 1'b0;
                                r_byte_cnt  <= '0;
                                r_state     <= ST_WAIT_NET;
                            end
                            c_type_none, c_type_rsvd: begin
                                // consumed and dropped
                            end
                            default: begin
                            end
                        endcase
                    end
                end

                ST_WAIT_NET: begin
                    if (!netBusy) begin
                        sendSignal <= 1'b1;
                        packetOut  <= hdr_byte(r_pkt_audio ? c_type_audio
                                                           : c_type_ctrl);
                        r_state    <= ST_HEADER;
                    end
                end

                ST_HEADER: begin
                    packetOut  <= w_pay_byte;
                    r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                    r_state    <= ST_PAYLOAD;
                end

                ST_PAYLOAD: begin
                    if (w_last_byte) begin
                        sendSignal <= 1'b0;
                        packetOut  <= 8'h00;
                        r_byte_cnt <= '0;
                        if (r_pkt_audio) begin
                            r_wr_ptr <= '0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_state  <= r_ret_fill ? ST_FILL : ST_IDLE;
                        end
                    end else begin
                        packetOut  <= w_pay_byte;
                        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : transport_send
`default_nettype wire
